// File: rtl/xillybus_lite_irq_ctrl_if.sv
// xillybus_lite user-port bus bundle for the interrupt controller.
//   master : the xillybus_lite core side (drives strobes, address and write data)
//   slave  : the register window (returns read data and its hit flag)
// Signals:
//   user_wren     write strobe, single cycle
//   user_wstrb    byte enables for user_wr_data
//   user_wr_data  write data
//   user_rden     read strobe, single cycle
//   user_addr     byte address
//   user_rd_data  read data, valid the cycle after user_rden
//   rd_hit        high with user_rd_data when the read hit the window
interface xillybus_lite_irq_ctrl_if;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic [31:0] user_wr_data;
  logic        user_rden;
  logic [31:0] user_addr;
  logic [31:0] user_rd_data;
  logic        rd_hit;

  modport master (
    output user_wren, user_wstrb, user_wr_data, user_rden, user_addr,
    input  user_rd_data, rd_hit
  );

  modport slave (
    input  user_wren, user_wstrb, user_wr_data, user_rden, user_addr,
    output user_rd_data, rd_hit
  );
endinterface

// File: rtl/xillybus_lite_irq_ctrl.sv
// Interrupt controller and register slice on the xillybus_lite user port.
// Rising edges on irq_src are latched into PENDING, gated by MASK, and a
// sequencer issues single-cycle user_irq pulses, rate-limited by HOLDOFF and
// repeated every REFIRE cycles while the host leaves the interrupt pending.
// Ports:
//   user_clk  in   clock
//   user_rst  in   synchronous reset, active-high
//   bus       slave side of the xillybus_lite user bus (32-byte window at BASE)
//   irq_src   in   N_SRC level sources, synchronous to user_clk
//   user_irq  out  one-cycle interrupt pulse
// Register map (byte offsets): 00 ID, 04 PENDING (W1C), 08 MASK, 0C FORCE (WO),
//   10 HOLDOFF[15:0], 14 REFIRE[23:0], 18 IRQCNT, 1C STATUS {[8] active, [1:0] state}
module xillybus_lite_irq_ctrl #(
  parameter int unsigned N_SRC  = 8,
  parameter logic [31:0] BASE   = 32'h0,
  parameter logic [31:0] ID_VAL = 32'h1C0
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  xillybus_lite_irq_ctrl_if.slave   bus,
  input  logic [N_SRC-1:0]          irq_src,
  output logic                      user_irq
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [2:0] R_ID      = 3'd0;
  localparam logic [2:0] R_PENDING = 3'd1;
  localparam logic [2:0] R_MASK    = 3'd2;
  localparam logic [2:0] R_FORCE   = 3'd3;
  localparam logic [2:0] R_HOLDOFF = 3'd4;
  localparam logic [2:0] R_REFIRE  = 3'd5;
  localparam logic [2:0] R_IRQCNT  = 3'd6;
  localparam logic [2:0] R_STATUS  = 3'd7;

  state_t           state_q;
  logic             irq_q;
  logic [31:0]      irqcnt_q;
  logic [15:0]      hold_cnt_q;
  logic [23:0]      ref_cnt_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [15:0]      holdoff_q, holdoff_d;
  logic [23:0]      refire_q, refire_d;
  logic [31:0]      rd_data_q;
  logic             rd_hit_q;

  logic             hit;
  logic [2:0]       idx;
  logic             wr_ok;
  logic [31:0]      bmask;
  logic [31:0]      wdat;
  logic             active;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] force_set;
  logic [31:0]      rmux;
  logic             unused_addr_lsb;

  assign hit    = (bus.user_addr[31:5] == BASE[31:5]);
  assign idx    = bus.user_addr[4:2];
  assign wr_ok  = bus.user_wren && hit;
  assign bmask  = {{8{bus.user_wstrb[3]}}, {8{bus.user_wstrb[2]}},
                   {8{bus.user_wstrb[1]}}, {8{bus.user_wstrb[0]}}};
  assign wdat   = bus.user_wr_data & bmask;
  assign active = |(pend_q & mask_q);
  assign rise   = irq_src & ~src_q;

  // Word-aligned window: the two byte-offset bits carry no information.
  assign unused_addr_lsb = &{1'b0, bus.user_addr[1:0]};

  always_comb begin
    w1c       = '0;
    force_set = '0;
    mask_d    = mask_q;
    holdoff_d = holdoff_q;
    refire_d  = refire_q;
    if (wr_ok) begin
      case (idx)
        R_PENDING: w1c       = wdat[N_SRC-1:0];
        R_FORCE:   force_set = wdat[N_SRC-1:0];
        R_MASK:    mask_d    = (mask_q & ~bmask[N_SRC-1:0]) | wdat[N_SRC-1:0];
        R_HOLDOFF: holdoff_d = (holdoff_q & ~bmask[15:0]) | wdat[15:0];
        R_REFIRE:  refire_d  = (refire_q & ~bmask[23:0]) | wdat[23:0];
        default:   ;
      endcase
    end
    // Sets are applied after the clear so a same-cycle edge/FORCE wins over W1C.
    pend_d = (pend_q & ~w1c) | rise | force_set;
  end

  always_comb begin
    rmux = '0;
    case (idx)
      R_ID:      rmux = ID_VAL;
      R_PENDING: rmux = 32'(pend_q);
      R_MASK:    rmux = 32'(mask_q);
      R_HOLDOFF: rmux = {16'd0, holdoff_q};
      R_REFIRE:  rmux = {8'd0, refire_q};
      R_IRQCNT:  rmux = irqcnt_q;
      R_STATUS:  rmux = {23'd0, active, 6'd0, state_q};
      default:   rmux = '0;
    endcase
  end

  // Edge history follows the sources even during reset, so a line held high
  // across reset is seen as already high and does not register as an edge.
  always_ff @(posedge user_clk) begin
    src_q <= irq_src;
    if (user_rst) begin
      pend_q    <= '0;
      mask_q    <= '0;
      holdoff_q <= 16'd64;
      refire_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      holdoff_q <= holdoff_d;
      refire_q  <= refire_d;
    end
  end

  // Pulse sequencer. user_irq is registered and high exactly while in FIRE.
  // The refire timer counts cycles since the pulse, the FIRE cycle being
  // count 0, so the first WAIT_ACK cycle already sees 1.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      irqcnt_q   <= '0;
      hold_cnt_q <= '0;
      ref_cnt_q  <= '0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (active) begin
            state_q <= FIRE;
            irq_q   <= 1'b1;
          end
        end
        FIRE: begin
          irqcnt_q  <= irqcnt_q + 32'd1;
          ref_cnt_q <= 24'd1;
          state_q   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!active) begin
            state_q    <= HOLD;
            hold_cnt_q <= holdoff_q;
          end else if ((refire_q != 24'd0) && (ref_cnt_q >= refire_q - 24'd1)) begin
            state_q    <= HOLD;
            hold_cnt_q <= holdoff_q;
          end else begin
            ref_cnt_q <= ref_cnt_q + 24'd1;
          end
        end
        HOLD: begin
          if (hold_cnt_q == 16'd0) begin
            if (active) begin
              state_q <= FIRE;
              irq_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fixed one-cycle read latency; a miss returns zero with rd_hit low.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      rd_hit_q  <= bus.user_rden && hit;
      rd_data_q <= (bus.user_rden && hit) ? rmux : 32'd0;
    end
  end

  assign bus.user_rd_data = rd_data_q;
  assign bus.rd_hit       = rd_hit_q;
  assign user_irq         = irq_q;

endmodule

// File: tb/tb_xillybus_lite_irq_ctrl.sv
// Directed testbench for xillybus_lite_irq_ctrl (N_SRC=32, BASE=0x1000).
module tb_xillybus_lite_irq_ctrl;

  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] A_ID      = BASE + 32'h00;
  localparam logic [31:0] A_PENDING = BASE + 32'h04;
  localparam logic [31:0] A_MASK    = BASE + 32'h08;
  localparam logic [31:0] A_FORCE   = BASE + 32'h0C;
  localparam logic [31:0] A_HOLDOFF = BASE + 32'h10;
  localparam logic [31:0] A_REFIRE  = BASE + 32'h14;
  localparam logic [31:0] A_IRQCNT  = BASE + 32'h18;
  localparam logic [31:0] A_STATUS  = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src = 32'd0;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int irq_n = 0;
  int irq_t [64];

  always #5 clk = ~clk;

  xillybus_lite_irq_ctrl_if bus ();

  xillybus_lite_irq_ctrl #(
    .N_SRC (32),
    .BASE  (BASE),
    .ID_VAL(32'h1C0)
  ) dut (
    .user_clk(clk),
    .user_rst(rst),
    .bus     (bus),
    .irq_src (src),
    .user_irq(irq)
  );

  // Pulse monitor: counts user_irq cycles and logs the cycle of each.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (irq) begin
      if (irq_n < 64) irq_t[irq_n] <= cyc;
      irq_n <= irq_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.user_addr    = a;
    bus.user_wr_data = d;
    bus.user_wstrb   = s;
    bus.user_wren    = 1'b1;
    tick(1);
    bus.user_wren    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.user_addr = a;
    bus.user_rden = 1'b1;
    tick(1);
    bus.user_rden = 1'b0;
    d = bus.user_rd_data;
    h = bus.rd_hit;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    rd(a, d, h);
    check(tag, d, exp);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    int          base;

    bus.user_wren    = 1'b0;
    bus.user_rden    = 1'b0;
    bus.user_wstrb   = 4'h0;
    bus.user_wr_data = 32'd0;
    bus.user_addr    = 32'd0;

    // Reset state
    tick(3);
    check("rst.irq", {31'd0, irq}, 32'd0);
    check("rst.rd_hit", {31'd0, bus.rd_hit}, 32'd0);
    check("rst.rd_data", bus.user_rd_data, 32'd0);
    rst = 1'b0;
    tick(1);
    rd_chk("rst.mask", A_MASK, 32'd0);
    rd_chk("rst.holdoff", A_HOLDOFF, 32'd64);
    rd_chk("rst.refire", A_REFIRE, 32'd0);

    // T1: ID read latency and out-of-window read
    rd(A_ID, d, h);
    check("t1.id", d, 32'h1C0);
    check("t1.id_hit", {31'd0, h}, 32'd1);
    tick(1);
    check("t1.hit_drop", {31'd0, bus.rd_hit}, 32'd0);
    rd(BASE + 32'h20, d, h);
    check("t1.miss_hit", {31'd0, h}, 32'd0);
    check("t1.miss_data", d, 32'd0);

    // T2: single masked source, one pulse, ack and 65-cycle hold
    base = irq_n;
    wr(A_MASK, 32'h1, 4'hF);
    src = 32'h1;
    tick(1);
    src = 32'h0;
    tick(5);
    check("t2.npulse", irq_n - base, 32'd1);
    rd_chk("t2.pending", A_PENDING, 32'h1);
    rd_chk("t2.irqcnt", A_IRQCNT, 32'd1);
    rd_chk("t2.status_wait", A_STATUS, 32'h102);
    wr(A_PENDING, 32'h1, 4'hF);
    rd_chk("t2.status_ack", A_STATUS, 32'h002);
    tick(63);
    rd_chk("t2.status_hold64", A_STATUS, 32'h003);
    rd_chk("t2.status_hold65", A_STATUS, 32'h003);
    rd_chk("t2.status_idle", A_STATUS, 32'h000);
    rd_chk("t2.pending_clr", A_PENDING, 32'h0);
    check("t2.npulse_end", irq_n - base, 32'd1);

    // T3: masked-off edge stays pending, unmask fires two cycles later
    base = irq_n;
    wr(A_MASK, 32'h0, 4'hF);
    src = 32'h8;
    tick(1);
    src = 32'h0;
    tick(3);
    rd_chk("t3.pending", A_PENDING, 32'h8);
    check("t3.no_pulse", irq_n - base, 32'd0);
    wr(A_MASK, 32'h8, 4'hF);
    check("t3.irq_c1", {31'd0, irq}, 32'd0);
    tick(1);
    check("t3.irq_c2", {31'd0, irq}, 32'd1);
    tick(1);
    check("t3.irq_c3", {31'd0, irq}, 32'd0);
    wr(A_PENDING, 32'h8, 4'hF);
    tick(70);

    // T4: refire without ack, pulses 111 cycles apart
    reset_dut();
    wr(A_MASK, 32'h8, 4'hF);
    wr(A_HOLDOFF, 32'd10, 4'hF);
    wr(A_REFIRE, 32'd100, 4'hF);
    base = irq_n;
    wr(A_FORCE, 32'h8, 4'hF);
    for (int k = 0; k < 400 && (irq_n - base) < 3; k++) tick(1);
    check("t4.npulse", irq_n - base, 32'd3);
    check("t4.gap1", irq_t[base + 1] - irq_t[base], 32'd111);
    check("t4.gap2", irq_t[base + 2] - irq_t[base + 1], 32'd111);
    tick(1);
    rd_chk("t4.irqcnt", A_IRQCNT, 32'd3);

    // T5: set beats W1C, byte-lane writes, read-only and write-only regs
    reset_dut();
    src = 32'h4;
    wr(A_PENDING, 32'h4, 4'hF);
    src = 32'h0;
    rd_chk("t5.set_wins", A_PENDING, 32'h4);
    wr(A_PENDING, 32'h4, 4'h0);
    rd_chk("t5.w1c_nostrb", A_PENDING, 32'h4);
    wr(A_PENDING, 32'h4, 4'h1);
    rd_chk("t5.w1c_strb", A_PENDING, 32'h0);
    wr(A_MASK, 32'hFFFF_FFFF, 4'b0010);
    rd_chk("t5.mask_lane", A_MASK, 32'h0000_FF00);
    wr(A_HOLDOFF, 32'hFFFF_FFFF, 4'b0001);
    rd_chk("t5.holdoff_lane", A_HOLDOFF, 32'h0000_00FF);
    wr(A_ID, 32'h0, 4'hF);
    rd_chk("t5.id_ro", A_ID, 32'h1C0);
    rd_chk("t5.force_rd", A_FORCE, 32'h0);

    // T6: reset during HOLD with the interrupt still active
    reset_dut();
    wr(A_MASK, 32'h1, 4'hF);
    wr(A_HOLDOFF, 32'd200, 4'hF);
    wr(A_REFIRE, 32'd2, 4'hF);
    wr(A_FORCE, 32'h1, 4'hF);
    tick(10);
    rd_chk("t6.status_hold", A_STATUS, 32'h103);
    src = 32'h20;
    tick(1);
    base = irq_n;
    rst = 1'b1;
    tick(3);
    check("t6.irq_in_rst", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    tick(300);
    check("t6.no_pulse", irq_n - base, 32'd0);
    rd_chk("t6.pending", A_PENDING, 32'h0);
    rd_chk("t6.irqcnt", A_IRQCNT, 32'd0);
    rd_chk("t6.holdoff", A_HOLDOFF, 32'd64);
    rd_chk("t6.status", A_STATUS, 32'h000);
    src = 32'h0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
